// File: rtl/multi_cycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, counts retired instructions and flags unsupported opcodes.
module multi_cycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       memRead,
    output logic       memWrite,
    output logic       iorD,
    output logic       irWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic       pcEn,
    output logic [3:0] state,
    output logic [15:0] instCount,
    output logic       illegal
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
        BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11
    } stateT;

    localparam logic [5:0] opRtype = 6'b000000;
    localparam logic [5:0] opLw    = 6'b100011;
    localparam logic [5:0] opSw    = 6'b101011;
    localparam logic [5:0] opBeq   = 6'b000100;
    localparam logic [5:0] opJ     = 6'b000010;
    localparam logic [5:0] opAddi  = 6'b001000;

    stateT curState, nextState;
    logic  retire, badOp;
    logic  pcWrite, pcWriteCond;

    assign state = curState;

    // Next state; unused encodings 12-15 fall through to FETCH.
    always_comb begin
        nextState = FETCH;
        retire    = 1'b0;
        badOp     = 1'b0;
        case (curState)
            FETCH:  nextState = DECODE;
            DECODE: begin
                case (opcode)
                    opLw, opSw: nextState = MEMADR;
                    opRtype:    nextState = EXEC;
                    opBeq:      nextState = BRANCH;
                    opJ:        nextState = JUMP;
                    opAddi:     nextState = ADDIEX;
                    default:    badOp     = 1'b1;
                endcase
            end
            MEMADR: nextState = (opcode == opLw) ? MEMRD : MEMWR;
            MEMRD:  nextState = MEMWB;
            EXEC:   nextState = RWB;
            ADDIEX: nextState = ADDIWB;
            MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB: retire = 1'b1;
            default: nextState = FETCH;
        endcase
    end

    // Moore outputs; held low during reset so FETCH cannot load PC/IR.
    always_comb begin
        regWrite    = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        iorD        = 1'b0;
        irWrite     = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        if (!reset) begin
            case (curState)
                FETCH: begin
                    memRead = 1'b1; irWrite = 1'b1; aluSrcB = 2'b01; pcWrite = 1'b1;
                end
                DECODE: aluSrcB = 2'b11;
                MEMADR, ADDIEX: begin
                    aluSrcA = 1'b1; aluSrcB = 2'b10;
                end
                MEMRD: begin
                    memRead = 1'b1; iorD = 1'b1;
                end
                MEMWB: begin
                    regWrite = 1'b1; memToReg = 1'b1;
                end
                MEMWR: begin
                    memWrite = 1'b1; iorD = 1'b1;
                end
                EXEC: begin
                    aluSrcA = 1'b1; aluOp = 2'b10;
                end
                RWB: begin
                    regWrite = 1'b1; regDst = 1'b1;
                end
                BRANCH: begin
                    aluSrcA = 1'b1; aluOp = 2'b01; pcWriteCond = 1'b1; pcSource = 2'b01;
                end
                JUMP: begin
                    pcWrite = 1'b1; pcSource = 2'b10;
                end
                ADDIWB: regWrite = 1'b1;
                default: ;
            endcase
        end
        pcEn = pcWrite | (pcWriteCond & zero);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            curState  <= FETCH;
            instCount <= 16'd0;
            illegal   <= 1'b0;
        end else begin
            curState <= nextState;
            if (retire) instCount <= instCount + 16'd1;
            if (badOp)  illegal   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: a per-instruction state-path model checked every cycle,
// plus directed latency/counter/flag expectations.
module tb_multi_cycle_ctrl;
    logic        clk = 1'b0;
    logic        reset, zero;
    logic [5:0]  opcode;
    logic        regWrite, regDst, memToReg, memRead, memWrite, iorD, irWrite, aluSrcA, pcEn;
    logic [1:0]  aluSrcB, aluOp, pcSource;
    logic [3:0]  state;
    logic [15:0] instCount;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    multi_cycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg), .memRead(memRead),
        .memWrite(memWrite), .iorD(iorD), .irWrite(irWrite), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource), .pcEn(pcEn),
        .state(state), .instCount(instCount), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Control vector {regWrite,regDst,memToReg,memRead,memWrite,iorD,irWrite,aluSrcA,aluSrcB,aluOp,pcSource,pcEn}
    function automatic logic [14:0] expCtrl(input int st, input logic rst, input logic z);
        logic rw, rd, m2r, mr, mw, io, irw, sa, pw, pwc;
        logic [1:0] sb, op, ps;
        {rw, rd, m2r, mr, mw, io, irw, sa, pw, pwc} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        if (!rst) begin
            case (st)
                0:  begin mr = 1; irw = 1; sb = 2'b01; pw = 1; end
                1:  sb = 2'b11;
                2, 10: begin sa = 1; sb = 2'b10; end
                3:  begin mr = 1; io = 1; end
                4:  begin rw = 1; m2r = 1; end
                5:  begin mw = 1; io = 1; end
                6:  begin sa = 1; op = 2'b10; end
                7:  begin rw = 1; rd = 1; end
                8:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
                9:  begin pw = 1; ps = 2'b10; end
                11: rw = 1;
                default: ;
            endcase
        end
        return {rw, rd, m2r, mr, mw, io, irw, sa, sb, op, ps, pw | (pwc & z)};
    endfunction

    // Model: at DECODE the opcode selects the remaining path; an empty path returns to FETCH.
    int          expState = 0;
    logic [15:0] expCount = 16'd0;
    logic        expIllegal = 1'b0;
    logic        started = 1'b0;
    int          path[$];

    initial forever begin
        @(posedge clk);
        if (reset) begin
            path.delete(); expState = 0; expCount = 16'd0; expIllegal = 1'b0; started = 1'b1;
        end else if (started) begin
            if (expState == 0) expState = 1;
            else begin
                if (expState == 1) begin
                    case (opcode)
                        6'b100011: path = '{2, 3, 4};
                        6'b101011: path = '{2, 5};
                        6'b000000: path = '{6, 7};
                        6'b000100: path = '{8};
                        6'b000010: path = '{9};
                        6'b001000: path = '{10, 11};
                        default:   begin path.delete(); expIllegal = 1'b1; end
                    endcase
                    if (path.size() == 0) expState = 0;
                    else expState = path.pop_front();
                end else if (path.size() == 0) begin
                    expState = 0;
                    expCount = expCount + 16'd1;
                end else expState = path.pop_front();
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("state", {28'd0, state}, expState);
            check("ctrl", {17'd0, regWrite, regDst, memToReg, memRead, memWrite, iorD, irWrite,
                           aluSrcA, aluSrcB, aluOp, pcSource, pcEn}, {17'd0, expCtrl(expState, reset, zero)});
            check("instCount", {16'd0, instCount}, {16'd0, expCount});
            check("illegal", {31'd0, illegal}, {31'd0, expIllegal});
        end
    end

    task automatic runInstr(input logic [5:0] op, input logic z, input int expCyc, input string nm);
        int n;
        opcode = op; zero = z; n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (state != 4'd0 && n < 20);
        check(nm, n, expCyc);
    endtask

    initial begin
        reset = 1'b1; opcode = 6'd0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {28'd0, state}, 0);
        check("reset_ctrl_pcEn", {31'd0, pcEn}, 0);
        reset = 1'b0;
        #1;
        check("fetch_pcEn", {31'd0, pcEn}, 1);

        runInstr(6'b100011, 1'b0, 5, "lw_cycles");
        check("lw_count", {16'd0, instCount}, 1);
        runInstr(6'b101011, 1'b0, 4, "sw_cycles");
        runInstr(6'b000000, 1'b0, 4, "rtype_cycles");
        check("sw_r_count", {16'd0, instCount}, 3);
        runInstr(6'b000100, 1'b1, 3, "beq_taken_cycles");
        runInstr(6'b000100, 1'b0, 3, "beq_not_cycles");
        check("beq_count", {16'd0, instCount}, 5);
        runInstr(6'b111111, 1'b0, 2, "illegal_cycles");
        check("illegal_flag", {31'd0, illegal}, 1);
        check("illegal_count", {16'd0, instCount}, 5);
        runInstr(6'b001000, 1'b0, 4, "addi_cycles");
        check("addi_count", {16'd0, instCount}, 6);
        check("illegal_sticky", {31'd0, illegal}, 1);
        runInstr(6'b000010, 1'b0, 3, "j_cycles");

        // Reset in MEMRD of a lw: outputs drop at once, no retire.
        opcode = 6'b100011;
        repeat (3) begin @(posedge clk); #1; end
        check("pre_rst_state", {28'd0, state}, 3);
        reset = 1'b1;
        #1;
        check("rst_memRead", {31'd0, memRead}, 0);
        check("rst_regWrite", {31'd0, regWrite}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_state", {28'd0, state}, 0);
        check("rst_count", {16'd0, instCount}, 0);
        check("rst_illegal", {31'd0, illegal}, 0);

        // Counter wrap: preload 0xFFFF in JUMP, then the retiring edge wraps it.
        opcode = 6'b000010;
        repeat (2) begin @(posedge clk); #1; end
        check("jump_state", {28'd0, state}, 9);
        force dut.instCount = 16'hFFFF;
        expCount = 16'hFFFF;
        #1;
        release dut.instCount;
        check("preload", {16'd0, instCount}, 32'h0000FFFF);
        @(posedge clk); #1;
        check("wrap", {16'd0, instCount}, 0);
        runInstr(6'b000010, 1'b0, 3, "j_after_wrap");
        check("after_wrap_count", {16'd0, instCount}, 1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
